cache_arbiter: RTL and testbench

- Shares a single cache_top instance between NUM_REQ requesters, such as two processor ports or a CPU plus a DMA engine.
- Accepts one request at a time using round-robin priority.
- Issues a one-cycle re/we strobe to the cache, waits for cache done, then returns the read data and a one-cycle response to the granted requester.
- A watchdog counter converts a missing done into an error response so the block cannot hang.

---
 rtl/cache_arb_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/cache_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cache_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and width helpers for the cache arbiter.
package cache_arb_pkg;

    // Arbiter transaction states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int unsigned DEF_TIMEOUT = 15;

    // Address width for a backing RAM of the given depth
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Requester-index width (at least one bit)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Watchdog counter width; it must be able to hold TIMEOUT itself
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   req        - request vector
//   advance    - a grant is being taken; pointer moves past grant_idx
//   grant      - one-hot grant (combinational)
//   grant_idx  - index of the granted requester (combinational)
module rr_arbiter
    import cache_arb_pkg::*;
#(
    parameter  int unsigned N     = 2,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   cand;
    logic             found;

    // Scan N positions starting at the pointer, wrapping modulo N
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(N)) begin
                cand = cand - (IDX_W + 1)'(N);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer moves to the requester after the one just served
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cache between NUM_REQ requesters, one transaction at a time.
// Flow: IDLE accept -> ISSUE one-cycle re/we strobe -> WAIT for done (or
// watchdog) -> RESP one-cycle completion pulse to the granted requester.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   req_valid/we/addr/wdata- per-requester request (addr/wdata flattened)
//   req_ready              - one-hot accept, combinational in IDLE
//   resp_valid             - one-hot one-cycle completion pulse
//   resp_rdata, resp_err   - read data / timeout flag, held until next RESP
//   cache_we/re/addr/wdata - to cache_top
//   cache_done/rdata       - from cache_top
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned RAM_DEPTH = 256,
    parameter  int unsigned NUM_REQ   = 2,
    parameter  int unsigned TIMEOUT   = DEF_TIMEOUT,
    localparam int unsigned ADDR_W    = addr_width(RAM_DEPTH),
    localparam int unsigned IDX_W     = idx_width(NUM_REQ),
    localparam int unsigned CNT_W     = cnt_width(TIMEOUT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [WIDTH-1:0]          resp_rdata,
    output logic                      resp_err,
    output logic                      cache_we,
    output logic                      cache_re,
    output logic [ADDR_W-1:0]         cache_addr,
    output logic [WIDTH-1:0]          cache_wdata,
    input  logic                      cache_done,
    input  logic [WIDTH-1:0]          cache_rdata
);

    arb_state_e         state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic               cache_we_q, cache_we_d;
    logic               cache_re_q, cache_re_d;
    logic               accept_c;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]   wdata_arr [NUM_REQ];

    // Unflatten per-requester address and write data
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*WIDTH +: WIDTH];
    end

    // The pointer advances at accept rather than at RESP: no arbitration
    // happens in between, so the grant order is the same either way.
    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept_c),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        resp_valid_d = '0;
        cache_we_d   = 1'b0;
        cache_re_d   = 1'b0;
        accept_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    accept_c   = 1'b1;
                    we_d       = req_we[grant_idx];
                    addr_d     = addr_arr[grant_idx];
                    wdata_d    = wdata_arr[grant_idx];
                    idx_d      = grant_idx;
                    cache_we_d = req_we[grant_idx];
                    cache_re_d = !req_we[grant_idx];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // done takes precedence over an expiring watchdog
                if (cache_done) begin
                    rdata_d             = we_q ? '0 : cache_rdata;
                    err_d               = 1'b0;
                    resp_valid_d[idx_q] = 1'b1;
                    state_d             = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d             = '0;
                    err_d               = 1'b1;
                    resp_valid_d[idx_q] = 1'b1;
                    state_d             = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= '0;
            cache_we_q   <= 1'b0;
            cache_re_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            cache_we_q   <= cache_we_d;
            cache_re_q   <= cache_re_d;
        end
    end

    // Ready is combinational; masked by rst so every output is 0 in reset
    assign req_ready   = (state_q == ST_IDLE && !rst) ? grant : '0;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign cache_we    = cache_we_q;
    assign cache_re    = cache_re_q;
    assign cache_addr  = addr_q;
    assign cache_wdata = wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter with a stub cache and a reference model.
module tb_cache_arbiter;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned RAM_DEPTH = 256;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned TIMEOUT   = 15;
    localparam int          NEVER     = 1000;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_we = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*WIDTH-1:0]  req_wdata = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [WIDTH-1:0]          resp_rdata;
    logic                      resp_err;
    logic                      cache_we;
    logic                      cache_re;
    logic [ADDR_W-1:0]         cache_addr;
    logic [WIDTH-1:0]          cache_wdata;
    logic                      cache_done = 1'b0;
    logic [WIDTH-1:0]          cache_rdata = '0;

    cache_arbiter #(
        .WIDTH     (WIDTH),
        .RAM_DEPTH (RAM_DEPTH),
        .NUM_REQ   (NUM_REQ),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .cache_we    (cache_we),
        .cache_re    (cache_re),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_done  (cache_done),
        .cache_rdata (cache_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         dly;
    } strobe_t;

    typedef struct {
        int         cyc;
        int         idx;
        logic [7:0] rdata;
        bit         err;
    } resp_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cycle = -1;
    int force_delay = -1;

    logic [7:0] stub_mem  [RAM_DEPTH];
    logic [7:0] model_mem [RAM_DEPTH];
    logic       stub_we;
    logic [7:0] stub_addr;
    logic [7:0] stub_wdata;

    strobe_t strobe_q[$];
    resp_t   resp_q[$];
    bit      model_idle = 1'b1;
    int      model_ptr = 0;
    bit      cur_valid = 1'b0;
    logic [7:0] cur_addr;
    logic [NUM_REQ-1:0] accepted = '0;

    // monitor temporaries
    int         sel, cidx, dly, deff;
    bit         m_we, m_err;
    logic [7:0] m_addr, m_wdata, m_rdata;
    logic [NUM_REQ-1:0] exp_ready;
    strobe_t    s_e;
    resp_t      r_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({req_ready, resp_valid, resp_rdata, resp_err,
                    cache_we, cache_re, cache_addr, cache_wdata});
    endfunction

    function automatic int pick_delay();
        int r;
        if (force_delay >= 0) return force_delay;
        r = int'($urandom_range(0, 19));
        if (r < 15) return 1 + (r % 4);
        if (r < 17) return TIMEOUT;
        if (r < 18) return TIMEOUT - 1;
        return NEVER;
    endfunction

    // Stub cache: raises done for one cycle on the planned cycle
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rst && cyc == done_cycle) begin
            cache_done = 1'b1;
            if (stub_we) begin
                stub_mem[stub_addr] = stub_wdata;
                cache_rdata = 8'($urandom_range(1, 255));
            end else begin
                cache_rdata = stub_mem[stub_addr];
            end
        end else begin
            cache_done  = 1'b0;
            cache_rdata = 8'($urandom);
        end
    end

    // Reference model + scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            chk("outputs_in_reset", all_outputs(), 32'd0);
            model_idle = 1'b1;
            model_ptr  = 0;
            cur_valid  = 1'b0;
            done_cycle = -1;
            accepted   = '0;
            strobe_q.delete();
            resp_q.delete();
        end else begin
            // Arbitration: first valid at/after pointer while idle
            sel = -1;
            exp_ready = '0;
            if (model_idle) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cidx = (model_ptr + k) % NUM_REQ;
                    if (sel < 0 && req_valid[cidx]) sel = cidx;
                end
            end
            if (sel >= 0) exp_ready[sel] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            accepted = exp_ready;

            if (sel >= 0) begin
                dly     = pick_delay();
                m_we    = req_we[sel];
                m_addr  = req_addr[sel*ADDR_W +: ADDR_W];
                m_wdata = req_wdata[sel*WIDTH +: WIDTH];
                m_err   = (dly > int'(TIMEOUT));
                deff    = m_err ? int'(TIMEOUT) : dly;
                m_rdata = (m_err || m_we) ? 8'h00 : model_mem[m_addr];
                if (m_we && !m_err) model_mem[m_addr] = m_wdata;
                strobe_q.push_back('{cyc + 1, m_we, m_addr, m_wdata, dly});
                resp_q.push_back('{cyc + 2 + deff, sel, m_rdata, m_err});
                model_idle = 1'b0;
                model_ptr  = (sel + 1) % NUM_REQ;
            end

            if (cur_valid) chk("cache_addr_stable", 32'(cache_addr), 32'(cur_addr));

            if (strobe_q.size() > 0 && strobe_q[0].cyc == cyc) begin
                s_e = strobe_q.pop_front();
                chk("cache_we", 32'(cache_we), 32'(s_e.we));
                chk("cache_re", 32'(cache_re), 32'(!s_e.we));
                chk("cache_addr", 32'(cache_addr), 32'(s_e.addr));
                chk("cache_wdata", 32'(cache_wdata), 32'(s_e.wdata));
                if (s_e.dly <= int'(TIMEOUT)) done_cycle = cyc + s_e.dly;
                stub_we    = cache_we;
                stub_addr  = cache_addr;
                stub_wdata = cache_wdata;
                cur_valid  = 1'b1;
                cur_addr   = s_e.addr;
            end else if (cache_we || cache_re) begin
                chk("unexpected_strobe", 32'({cache_we, cache_re}), 32'd0);
            end

            if (resp_q.size() > 0 && resp_q[0].cyc == cyc) begin
                r_e = resp_q.pop_front();
                chk("resp_valid", 32'(resp_valid), 32'(1) << r_e.idx);
                chk("resp_rdata", 32'(resp_rdata), 32'(r_e.rdata));
                chk("resp_err", 32'(resp_err), 32'(r_e.err));
                model_idle = 1'b1;
                cur_valid  = 1'b0;
            end else if (|resp_valid) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit we,
                           input logic [7:0] a, input logic [7:0] wd);
        req_valid[i] = v;
        req_we[i]    = we;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*WIDTH +: WIDTH]  = wd;
    endtask

    task automatic wait_accept(input int i);
        int n = 0;
        while (!accepted[i] && n < 100) begin
            step();
            n++;
        end
        if (!accepted[i]) chk("accept_wait", 32'd0, 32'd1);
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'b1, 1'($urandom_range(0, 1)),
                8'(8'h80 + $urandom_range(0, 15)), 8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < int'(RAM_DEPTH); i++) begin
            stub_mem[i]  = 8'($urandom);
            model_mem[i] = stub_mem[i];
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle: no requests, nothing may move
        repeat (10) step();

        // Single read, done one cycle after the strobe
        stub_mem[8'h12]  = 8'hA5;
        model_mem[8'h12] = 8'hA5;
        force_delay = 1;
        set_req(0, 1'b1, 1'b0, 8'h12, 8'h00);
        wait_accept(0);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (6) step();

        // Both requesters held valid: grants must alternate
        set_req(0, 1'b1, 1'b1, 8'h40, 8'h11);
        set_req(1, 1'b1, 1'b0, 8'h40, 8'h00);
        repeat (32) step();
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (6) step();

        // Watchdog: done never arrives
        force_delay = NEVER;
        set_req(1, 1'b1, 1'b0, 8'h33, 8'h00);
        wait_accept(1);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (22) step();

        // done on the very cycle the watchdog would fire: done wins
        force_delay = TIMEOUT;
        set_req(0, 1'b1, 1'b0, 8'h12, 8'h00);
        wait_accept(0);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (22) step();

        // Normal traffic resumes afterwards
        force_delay = 1;
        set_req(1, 1'b1, 1'b1, 8'h77, 8'h5C);
        wait_accept(1);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (6) step();

        // Reset in the middle of WAIT
        force_delay = NEVER;
        set_req(0, 1'b1, 1'b0, 8'h21, 8'h00);
        wait_accept(0);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) step();
        #3 rst = 1'b1;
        #1 chk("async_reset_outputs", all_outputs(), 32'd0);
        force_delay = 1;
        set_req(0, 1'b1, 1'b0, 8'h12, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h13, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_accept(0);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_accept(1);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (6) step();

        // One-cycle pulse from requester 1 while requester 0 is in WAIT
        force_delay = 6;
        set_req(0, 1'b1, 1'b0, 8'h55, 8'h00);
        wait_accept(0);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) step();
        set_req(1, 1'b1, 1'b0, 8'h66, 8'h00);
        step();
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (10) step();

        // Random traffic with random cache latency, drops and timeouts
        force_delay = -1;
        repeat (400) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accepted[i]) begin
                    if ($urandom_range(0, 2) == 0) req_valid[i] = 1'b0;
                    else rand_req(i);
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) rand_req(i);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            step();
        end
        req_valid = '0;
        repeat (40) step();

        chk("pending_responses", 32'(resp_q.size()), 32'd0);
        chk("pending_strobes", 32'(strobe_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
